// File: rtl/mix_cols_seq_pkg.sv
// rtl/mix_cols_seq_pkg.sv - shared types and GF(2^8) helpers for the MixColumns engine
package mix_cols_seq_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by one of the fixed MixColumns coefficients (1, 2, 3, 9, B, D, E).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            4'h2:    return x2;
            4'h3:    return x2 ^ a;
            4'h9:    return x8 ^ a;
            4'hB:    return x8 ^ x2 ^ a;
            4'hD:    return x8 ^ x4 ^ a;
            4'hE:    return x8 ^ x4 ^ x2;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/mix_cols_seq_unit.sv
// rtl/mix_cols_seq_unit.sv - combinational single-column MixColumns / InvMixColumns
module mix_col_unit
    import mix_cols_seq_pkg::*;
(
    input  aes_col_t col_i,
    input  logic     inverse_i,
    output aes_col_t col_o
);

    logic [7:0] a [4];
    logic [3:0] k [4];

    // Circulant matrix: output byte r uses k[j] against input byte (r+j) mod 4.
    always_comb begin
        if (inverse_i) begin
            k[0] = 4'hE;
            k[1] = 4'hB;
            k[2] = 4'hD;
            k[3] = 4'h9;
        end else begin
            k[0] = 4'h2;
            k[1] = 4'h3;
            k[2] = 4'h1;
            k[3] = 4'h1;
        end
        for (int r = 0; r < 4; r++) begin
            a[r] = col_i[31-8*r -: 8];
        end
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            col_o[31-8*r -: 8] = gf_mul(a[r], k[0])
                               ^ gf_mul(a[(r+1)%4], k[1])
                               ^ gf_mul(a[(r+2)%4], k[2])
                               ^ gf_mul(a[(r+3)%4], k[3]);
        end
    end

endmodule

// File: rtl/mix_cols_seq.sv
// rtl/mix_cols_seq.sv - iterative runtime-selectable MixColumns engine with valid/ready ports
module mix_cols_seq
    import mix_cols_seq_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    input  logic       in_inverse,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cpc
        $error("mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_e              state_q;
    logic [STEP_W-1:0] step_q;
    aes_state_t        work_q;
    aes_state_t        work_d;
    logic              inv_q;
    logic              out_valid_q;
    logic              busy_q;

    aes_col_t col_in  [COLS_PER_CYCLE];
    aes_col_t col_out [COLS_PER_CYCLE];

    // Pick the columns belonging to the current step out of the work register.
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col_in[j] = work_q[127 - 32*(int'(step_q)*COLS_PER_CYCLE + j) -: 32];
        end
    end

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_unit
        mix_col_unit u_unit (
            .col_i     (col_in[j]),
            .inverse_i (inv_q),
            .col_o     (col_out[j])
        );
    end

    // Work register with this step's columns replaced by their transformed values.
    always_comb begin
        work_d = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work_d[127 - 32*(int'(step_q)*COLS_PER_CYCLE + j) -: 32] = col_out[j];
        end
    end

    // Accept is combinational on out_ready so a result can retire and a new state enter in one cycle.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign out_state = work_q;
    assign busy      = busy_q;

    // Control FSM, step counter, work register and latched direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            work_q      <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        inv_q   <= in_inverse;
                        step_q  <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        step_q      <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q  <= in_state;
                            inv_q   <= in_inverse;
                            step_q  <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_cols_seq.sv
// tb/tb_mix_cols_seq.sv - scoreboard bench running every scenario for COLS_PER_CYCLE 1, 2 and 4
module tb_mix_cols_seq;
    import mix_cols_seq_pkg::*;

    localparam aes_state_t V0 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam aes_state_t V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam aes_state_t V2 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam aes_state_t V3 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

    logic clk;
    int   total;
    int   bad;
    int   cyc;
    bit   done_flag [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 3; i++) done_flag[i] = 1'b0;
    end

    // Shift-and-add GF(2^8) multiply, independent of the design's coefficient decomposition.
    function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic aes_state_t mix_ref(input aes_state_t s, input logic inv);
        logic [7:0] kk [4];
        logic [7:0] col [4];
        aes_state_t r;
        if (inv) begin
            kk[0] = 8'h0e; kk[1] = 8'h0b; kk[2] = 8'h0d; kk[3] = 8'h09;
        end else begin
            kk[0] = 8'h02; kk[1] = 8'h03; kk[2] = 8'h01; kk[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) col[b] = s[127 - 32*c - 8*b -: 8];
            for (int b = 0; b < 4; b++) begin
                r[127 - 32*c - 8*b -: 8] = gm(col[b], kk[0]) ^ gm(col[(b+1)%4], kk[1])
                                         ^ gm(col[(b+2)%4], kk[2]) ^ gm(col[(b+3)%4], kk[3]);
            end
        end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int CPC   = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int NSTEP = 4 / CPC;

        logic       rst_n;
        logic       in_valid;
        logic       in_ready;
        aes_state_t in_state;
        logic       in_inverse;
        logic       out_valid;
        logic       out_ready;
        aes_state_t out_state;
        logic       busy;

        aes_state_t q [$];
        logic       prev_v;
        logic       prev_hs;
        aes_state_t prev_s;

        mix_cols_seq #(.COLS_PER_CYCLE(CPC)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_state   (in_state),
            .in_inverse (in_inverse),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_state  (out_state),
            .busy       (busy)
        );

        task automatic chk(input string name, input aes_state_t act, input aes_state_t exp);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL cpc=%0d %s actual=%h required=%h", CPC, name, act, exp);
            end
        endtask

        task automatic send(input aes_state_t s, input logic inv, input aes_state_t exp,
                            output int acc_cyc);
            int n;
            in_valid   = 1'b1;
            in_state   = s;
            in_inverse = inv;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            acc_cyc = cyc;
            if (!in_ready) begin
                total++;
                bad++;
                $display("FAIL cpc=%0d accept_timeout actual=0 required=1", CPC);
                in_valid = 1'b0;
            end else begin
                q.push_back(exp);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("drained", aes_state_t'(q.size()), '0);
            @(posedge clk);
            #1;
        endtask

        // Scoreboard monitor: pops on every output handshake and guards hold-until-ready.
        always @(negedge clk) begin
            if (!rst_n) begin
                prev_v  = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_v && !prev_hs) begin
                    chk("valid_held", aes_state_t'(out_valid), 128'd1);
                    chk("state_held", out_state, prev_s);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL cpc=%0d unexpected_output actual=%h required=none", CPC, out_state);
                    end else begin
                        chk("out_state", out_state, q.pop_front());
                    end
                end
                prev_v  = out_valid;
                prev_hs = out_valid && out_ready;
                prev_s  = out_state;
            end
        end

        initial begin
            int         c0;
            int         c1;
            int         c2;
            int         n;
            aes_state_t s;
            aes_state_t e;

            rst_n      = 1'b0;
            in_valid   = 1'b0;
            in_state   = '0;
            in_inverse = 1'b0;
            out_ready  = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("rst_in_ready",  aes_state_t'(in_ready),  128'd1);
            chk("rst_out_valid", aes_state_t'(out_valid), 128'd0);
            chk("rst_busy",      aes_state_t'(busy),      128'd0);
            chk("rst_out_state", out_state, '0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            // Forward vectors with latency measurement.
            send(V0, 1'b0, V1, c0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 50);
            chk("latency", aes_state_t'(n), aes_state_t'(NSTEP + 1));
            chk("busy_done", aes_state_t'(busy), 128'd1);
            drain();

            // Inverse and second forward vector.
            send(V1, 1'b1, V0, c0);
            drain();
            send(V2, 1'b0, V3, c0);
            drain();

            // Backpressure: ten cycles of out_ready low while a new input waits.
            out_ready = 1'b0;
            send(V0, 1'b0, V1, c0);
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            in_valid   = 1'b1;
            in_state   = V2;
            in_inverse = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("bp_valid",    aes_state_t'(out_valid), 128'd1);
                chk("bp_state",    out_state, V1);
                chk("bp_in_ready", aes_state_t'(in_ready), 128'd0);
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("bp_released", aes_state_t'(out_valid), 128'd0);
            drain();

            // Back-to-back with alternating direction.
            send(V0, 1'b0, V1, c0);
            send(V1, 1'b1, V0, c1);
            send(V2, 1'b0, V3, c2);
            chk("b2b_gap1", aes_state_t'(c1 - c0), aes_state_t'(NSTEP + 1));
            chk("b2b_gap2", aes_state_t'(c2 - c1), aes_state_t'(NSTEP + 1));
            drain();

            // Mode isolation: inputs wiggle while the transaction runs.
            send(V0, 1'b0, V1, c0);
            for (int i = 0; i < NSTEP + 2; i++) begin
                in_inverse = ~in_inverse;
                in_state   = (i % 2 == 0) ? V2 : V3;
                @(posedge clk);
                #1;
            end
            drain();

            // Reset mid-RUN, then a clean transaction.
            send(V0, 1'b0, V1, c0);
            if (NSTEP > 1) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            #1;
            q.delete();
            chk("mid_rst_out_valid", aes_state_t'(out_valid), 128'd0);
            chk("mid_rst_in_ready",  aes_state_t'(in_ready),  128'd1);
            chk("mid_rst_busy",      aes_state_t'(busy),      128'd0);
            chk("mid_rst_state",     out_state, '0);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            send(V2, 1'b0, V3, c0);
            drain();

            // Random round trips against the reference model.
            for (int i = 0; i < 500; i++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                e = mix_ref(s, 1'b0);
                send(s, 1'b0, e, c0);
                send(e, 1'b1, s, c0);
            end
            drain();

            done_flag[g] = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(done_flag[0] && done_flag[1] && done_flag[2]) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(done_flag[0] && done_flag[1] && done_flag[2])) begin
            total++;
            bad++;
            $display("FAIL global_timeout actual=%0d required=<60000 cycles", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
